// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between an instruction master and
// a data master. A grant is decided combinationally each cycle. Accepted
// requests travel down a RESP_LAT-deep {valid, master_id} pipeline so that
// every response goes back to its owner in acceptance order.
// Optional feature macro ARB_RR_EN: when defined, ties are settled
// round-robin; when undefined, the data master always wins a tie.
module sram_arbiter #(
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic grant_inst;
  logic grant_data;

  // Response pipeline: bit 0 is the newest acceptance, bit RESP_LAT-1 returns.
  logic [RESP_LAT-1:0] vld_q, vld_d;
  logic [RESP_LAT-1:0] id_q, id_d;   // 1 = data master, 0 = instruction master
  logic resp_vld;
  logic resp_id;

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

`ifdef ARB_RR_EN
  // Set when the data master should win the next tie.
  logic rr_data_q, rr_data_d;

  // Flip the tie pointer only when a tie was actually settled.
  always_comb begin
    rr_data_d = rr_data_q;
    if (!reset && inst_req && data_req) begin
      rr_data_d = ~rr_data_q;
    end
  end

  // Tie pointer register; reset leaves data favoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_data_q <= 1'b1;
    end else begin
      rr_data_q <= rr_data_d;
    end
  end
`endif

  // Pick at most one requesting master; nothing is granted during reset.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
`ifdef ARB_RR_EN
        grant_data = rr_data_q;
        grant_inst = ~rr_data_q;
`else
        grant_data = 1'b1;
`endif
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  // Steer the winner onto the SRAM port and acknowledge it in the same cycle.
  always_comb begin
    ram_en       = grant_inst | grant_data;
    ram_wen      = 4'b0000;
    ram_addr     = 32'h0;
    ram_wdata    = 32'h0;
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    if (grant_data) begin
      ram_wen   = data_wr ? data_wstrb : 4'b0000;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (grant_inst) begin
      ram_wen   = inst_wr ? inst_wstrb : 4'b0000;
      ram_addr  = inst_addr;
      ram_wdata = inst_wdata;
    end
  end

  // Shift the acceptance record one stage per cycle; no bubbles are inserted.
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = ram_en;
    id_d[0]  = grant_data;
    for (int i = 1; i < RESP_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // Pipeline registers; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    id_q <= id_d;
  end

  // Route the returning response to its owner and keep each master's last read data.
  always_comb begin
    resp_vld     = vld_q[RESP_LAT-1] & ~reset;
    resp_id      = id_q[RESP_LAT-1];
    inst_data_ok = resp_vld & ~resp_id;
    data_data_ok = resp_vld & resp_id;
    inst_rdata_d = inst_data_ok ? ram_rdata : inst_rdata_q;
    data_rdata_d = data_data_ok ? ram_rdata : data_rdata_q;
    inst_rdata   = reset ? 32'h0 : inst_rdata_d;
    data_rdata   = reset ? 32'h0 : data_rdata_d;
  end

  // Hold registers for the last returned read data of each master.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: one instance with RESP_LAT=1 (a_*) and one with
// RESP_LAT=2 (b_*), each with its own behavioural SRAM. Expected responses are
// queued when requests are accepted and popped when data_ok appears.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        id;    // 1 = data master
    logic [31:0] data;
    logic        chk;   // compare rdata (reads only)
    int          cyc;   // acceptance cycle
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];
  ent_t ea;
  ent_t eb;

  // ---------------- DUT A (RESP_LAT = 1) ----------------
  logic a_ireq, a_iwr, a_iaok, a_idok;
  logic [3:0] a_iwstrb;
  logic [31:0] a_iaddr, a_iwdata, a_irdata;
  logic a_dreq, a_dwr, a_daok, a_ddok;
  logic [3:0] a_dwstrb;
  logic [31:0] a_daddr, a_dwdata, a_drdata;
  logic a_ram_en;
  logic [3:0] a_ram_wen;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

  sram_arbiter #(.RESP_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .inst_req(a_ireq), .inst_wr(a_iwr), .inst_wstrb(a_iwstrb), .inst_addr(a_iaddr),
    .inst_wdata(a_iwdata), .inst_addr_ok(a_iaok), .inst_data_ok(a_idok), .inst_rdata(a_irdata),
    .data_req(a_dreq), .data_wr(a_dwr), .data_wstrb(a_dwstrb), .data_addr(a_daddr),
    .data_wdata(a_dwdata), .data_addr_ok(a_daok), .data_data_ok(a_ddok), .data_rdata(a_drdata),
    .ram_en(a_ram_en), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  // ---------------- DUT B (RESP_LAT = 2) ----------------
  logic b_ireq, b_iwr, b_iaok, b_idok;
  logic [3:0] b_iwstrb;
  logic [31:0] b_iaddr, b_iwdata, b_irdata;
  logic b_dreq, b_dwr, b_daok, b_ddok;
  logic [3:0] b_dwstrb;
  logic [31:0] b_daddr, b_dwdata, b_drdata;
  logic b_ram_en;
  logic [3:0] b_ram_wen;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

  sram_arbiter #(.RESP_LAT(2)) u_b (
    .clk(clk), .reset(reset),
    .inst_req(b_ireq), .inst_wr(b_iwr), .inst_wstrb(b_iwstrb), .inst_addr(b_iaddr),
    .inst_wdata(b_iwdata), .inst_addr_ok(b_iaok), .inst_data_ok(b_idok), .inst_rdata(b_irdata),
    .data_req(b_dreq), .data_wr(b_dwr), .data_wstrb(b_dwstrb), .data_addr(b_daddr),
    .data_wdata(b_dwdata), .data_addr_ok(b_daok), .data_data_ok(b_ddok), .data_rdata(b_drdata),
    .ram_en(b_ram_en), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // Power-on memory contents.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return 32'hC0DE0000 + a;
  endfunction

  // SRAM A: one-cycle read, byte writes, single-word write overlay.
  logic        w_vld = 1'b0;
  logic [31:0] w_addr = 32'h0;
  logic [31:0] w_data = 32'h0;
  logic [31:0] a_rd = 32'h0;
  assign a_ram_rdata = a_rd;

  function automatic logic [31:0] mem_a_rd(input logic [31:0] a, input logic v,
                                           input logic [31:0] wa, input logic [31:0] wd);
    return (v && wa == a) ? wd : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (a_ram_en) begin
      a_rd <= mem_a_rd(a_ram_addr, w_vld, w_addr, w_data);
      if (a_ram_wen != 4'b0000) begin
        w_vld  <= 1'b1;
        w_addr <= a_ram_addr;
        w_data <= (mem_a_rd(a_ram_addr, w_vld, w_addr, w_data) &
                   ~{{8{a_ram_wen[3]}}, {8{a_ram_wen[2]}}, {8{a_ram_wen[1]}}, {8{a_ram_wen[0]}}}) |
                  (a_ram_wdata &
                   {{8{a_ram_wen[3]}}, {8{a_ram_wen[2]}}, {8{a_ram_wen[1]}}, {8{a_ram_wen[0]}}});
      end
    end
  end

  // SRAM B: two-cycle read, read-only contents.
  logic [31:0] b_rd0 = 32'h0;
  logic [31:0] b_rd1 = 32'h0;
  assign b_ram_rdata = b_rd1;
  always @(posedge clk) begin
    if (b_ram_en) b_rd0 <= init_word(b_ram_addr);
    b_rd1 <= b_rd0;
  end

  // Scoreboard A: responses must arrive in order, to the right master, 1 cycle after acceptance.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_idok || a_ddok) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_bad++;
          $display("FAIL a_unexpected_resp: inst_ok=%0b data_ok=%0b at cycle %0d, required none", a_idok, a_ddok, cyc);
        end else begin
          ea = q_a.pop_front();
          if ({a_ddok, a_idok} !== (ea.id ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL a_resp_owner: {data_ok,inst_ok}=%b, required %b", {a_ddok, a_idok}, ea.id ? 2'b10 : 2'b01);
          end
          n_cmp++;
          if (cyc !== ea.cyc + 1) begin
            n_bad++;
            $display("FAIL a_resp_latency: response cycle %0d, required %0d", cyc, ea.cyc + 1);
          end
          if (ea.chk) begin
            n_cmp++;
            if ((ea.id ? a_drdata : a_irdata) !== ea.data) begin
              n_bad++;
              $display("FAIL a_rdata: got %h, required %h", ea.id ? a_drdata : a_irdata, ea.data);
            end
          end
        end
      end else if (q_a.size() > 0 && cyc > q_a[0].cyc + 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_resp_missing: no data_ok by cycle %0d, required at %0d", cyc, q_a[0].cyc + 1);
        ea = q_a.pop_front();
      end
    end
  end

  // Scoreboard B: same checks with a 2-cycle response latency.
  always @(negedge clk) begin
    if (!reset) begin
      if (b_idok || b_ddok) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected_resp: inst_ok=%0b data_ok=%0b at cycle %0d, required none", b_idok, b_ddok, cyc);
        end else begin
          eb = q_b.pop_front();
          if ({b_ddok, b_idok} !== (eb.id ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL b_resp_owner: {data_ok,inst_ok}=%b, required %b", {b_ddok, b_idok}, eb.id ? 2'b10 : 2'b01);
          end
          n_cmp++;
          if (cyc !== eb.cyc + 2) begin
            n_bad++;
            $display("FAIL b_resp_latency: response cycle %0d, required %0d", cyc, eb.cyc + 2);
          end
          if (eb.chk) begin
            n_cmp++;
            if ((eb.id ? b_drdata : b_irdata) !== eb.data) begin
              n_bad++;
              $display("FAIL b_rdata: got %h, required %h", eb.id ? b_drdata : b_irdata, eb.data);
            end
          end
        end
      end else if (q_b.size() > 0 && cyc > q_b[0].cyc + 2) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_resp_missing: no data_ok by cycle %0d, required at %0d", cyc, q_b[0].cyc + 2);
        eb = q_b.pop_front();
      end
    end
  end

  task automatic idle_all();
    a_ireq = 1'b0; a_iwr = 1'b0; a_iwstrb = 4'h0; a_iaddr = 32'h0; a_iwdata = 32'h0;
    a_dreq = 1'b0; a_dwr = 1'b0; a_dwstrb = 4'h0; a_daddr = 32'h0; a_dwdata = 32'h0;
    b_ireq = 1'b0; b_iwr = 1'b0; b_iwstrb = 4'h0; b_iaddr = 32'h0; b_iwdata = 32'h0;
    b_dreq = 1'b0; b_dwr = 1'b0; b_dwstrb = 4'h0; b_daddr = 32'h0; b_dwdata = 32'h0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    // Requests pending while reset is held must not be granted.
    a_ireq = 1'b1; a_dreq = 1'b1; a_iaddr = 32'h100; a_daddr = 32'h104;
    b_dreq = 1'b1; b_daddr = 32'h108;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_iaok, a_daok, a_idok, a_ddok, a_ram_en, a_ram_wen} !== 9'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl_a: {iaok,daok,idok,ddok,en,wen}=%b, required 0", {a_iaok, a_daok, a_idok, a_ddok, a_ram_en, a_ram_wen});
      end
      n_cmp++;
      if ({a_irdata, a_drdata} !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_rdata_a: inst=%h data=%h, required 0", a_irdata, a_drdata);
      end
      n_cmp++;
      if ({b_daok, b_ram_en} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_ctrl_b: daok=%b en=%b, required 0", b_daok, b_ram_en);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_all();
    @(negedge clk);
    n_cmp++;
    if ({a_iaok, a_daok, a_ram_en, a_ram_wen} !== 7'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: {iaok,daok,en,wen}=%b, required 0", {a_iaok, a_daok, a_ram_en, a_ram_wen});
    end
    n_cmp++;
    if ({a_irdata, a_drdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL idle_rdata: inst=%h data=%h, required 0", a_irdata, a_drdata);
    end
  endtask

  task automatic test_inst_read();
    @(posedge clk); #1;
    a_ireq = 1'b1; a_iwr = 1'b0; a_iaddr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({a_iaok, a_daok, a_ram_en, a_ram_wen} !== 7'b1010000) begin
      n_bad++;
      $display("FAIL inst_read_grant: {iaok,daok,en,wen}=%b, required 1010000", {a_iaok, a_daok, a_ram_en, a_ram_wen});
    end
    n_cmp++;
    if (a_ram_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL inst_read_addr: ram_addr=%h, required 00000100", a_ram_addr);
    end
    q_a.push_back('{1'b0, 32'hDEADBEEF, 1'b1, cyc});
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_cmp++;
    if ({a_ddok, a_daok, a_drdata} !== 34'h0) begin
      n_bad++;
      $display("FAIL inst_read_data_side: ddok=%b daok=%b drdata=%h, required 0", a_ddok, a_daok, a_drdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (a_irdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL inst_rdata_hold: inst_rdata=%h, required deadbeef", a_irdata);
    end
  endtask

  task automatic test_contention();
    logic [31:0] ia;
    logic [31:0] da;
    logic exp_data;
    ia = 32'h300;
    da = 32'h400;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      a_ireq = 1'b1; a_iwr = 1'b0; a_iaddr = ia;
      a_dreq = 1'b1; a_dwr = 1'b0; a_daddr = da;
`ifdef ARB_RR_EN
      exp_data = (c % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      @(negedge clk);
      n_cmp++;
      if ({a_daok, a_iaok} !== {exp_data, ~exp_data}) begin
        n_bad++;
        $display("FAIL contention_grant%0d: {daok,iaok}=%b, required %b", c, {a_daok, a_iaok}, {exp_data, ~exp_data});
      end
      n_cmp++;
      if (a_ram_addr !== (exp_data ? da : ia)) begin
        n_bad++;
        $display("FAIL contention_addr%0d: ram_addr=%h, required %h", c, a_ram_addr, exp_data ? da : ia);
      end
      if (exp_data) begin
        q_a.push_back('{1'b1, init_word(da), 1'b1, cyc});
        da = da + 32'h4;
      end else begin
        q_a.push_back('{1'b0, init_word(ia), 1'b1, cyc});
        ia = ia + 32'h4;
      end
    end
    @(posedge clk); #1;
    idle_all();
    wait_cycles(3);
  endtask

  task automatic test_write_partial();
    logic [31:0] old;
    logic [31:0] exp;
    @(posedge clk); #1;
    a_dreq = 1'b1; a_dwr = 1'b1; a_dwstrb = 4'b0011; a_daddr = 32'h200; a_dwdata = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if ({a_daok, a_ram_en, a_ram_wen} !== 6'b110011) begin
      n_bad++;
      $display("FAIL write_wen: {daok,en,wen}=%b, required 110011", {a_daok, a_ram_en, a_ram_wen});
    end
    n_cmp++;
    if ({a_ram_addr, a_ram_wdata} !== {32'h200, 32'h12345678}) begin
      n_bad++;
      $display("FAIL write_bus: addr=%h wdata=%h, required 00000200 12345678", a_ram_addr, a_ram_wdata);
    end
    q_a.push_back('{1'b1, 32'h0, 1'b0, cyc});
    @(posedge clk); #1;
    idle_all();
    a_ireq = 1'b1; a_iwr = 1'b0; a_iaddr = 32'h200;
    @(negedge clk);
    n_cmp++;
    if ({a_iaok, a_ram_wen, a_ddok} !== 6'b100001) begin
      n_bad++;
      $display("FAIL read_after_write_grant: {iaok,wen,ddok}=%b, required 100001", {a_iaok, a_ram_wen, a_ddok});
    end
    old = init_word(32'h200);
    exp = {old[31:16], 16'h5678};
    q_a.push_back('{1'b0, exp, 1'b1, cyc});
    @(posedge clk); #1;
    idle_all();
    wait_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    addr = 32'h500;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      b_dreq = 1'b1; b_dwr = 1'b0; b_daddr = addr;
      @(negedge clk);
      n_cmp++;
      if ({b_daok, b_iaok, b_ram_en} !== 3'b101) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: {daok,iaok,en}=%b, required 101", c, {b_daok, b_iaok, b_ram_en});
      end
      q_b.push_back('{1'b1, init_word(addr), 1'b1, cyc});
      addr = addr + 32'h4;
    end
    @(posedge clk); #1;
    idle_all();
    wait_cycles(4);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    a_ireq = 1'b1; a_iwr = 1'b0; a_iaddr = 32'h100;
    b_dreq = 1'b1; b_dwr = 1'b0; b_daddr = 32'h600;
    @(negedge clk);
    n_cmp++;
    if ({a_iaok, b_daok} !== 2'b11) begin
      n_bad++;
      $display("FAIL midflight_accept: a_iaok=%b b_daok=%b, required 1 1", a_iaok, b_daok);
    end
    @(posedge clk); #1;
    idle_all();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_idok, a_ddok, a_iaok, a_daok, a_ram_en, a_ram_wen, b_idok, b_ddok, b_ram_en} !== 13'b0) begin
        n_bad++;
        $display("FAIL midflight_reset_ctrl%0d: a_idok=%b a_ddok=%b a_en=%b b_ddok=%b b_en=%b, required 0",
                 c, a_idok, a_ddok, a_ram_en, b_ddok, b_ram_en);
      end
      n_cmp++;
      if ({a_irdata, a_drdata, b_drdata} !== 96'h0) begin
        n_bad++;
        $display("FAIL midflight_reset_rdata%0d: a_i=%h a_d=%h b_d=%h, required 0", c, a_irdata, a_drdata, b_drdata);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_idok, a_ddok, b_idok, b_ddok} !== 4'b0) begin
        n_bad++;
        $display("FAIL midflight_stale_resp%0d: a_idok=%b b_ddok=%b, required 0", c, a_idok, b_ddok);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({a_irdata, b_drdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL midflight_rdata_cleared: a_irdata=%h b_drdata=%h, required 0", a_irdata, b_drdata);
    end
  endtask

  task automatic test_drain();
    n_cmp++;
    if (q_a.size() + q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", q_a.size() + q_b.size());
    end
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    test_reset();
    test_inst_read();
    test_contention();
    test_write_partial();
    test_back_to_back();
    test_reset_midflight();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
